// File: rtl/decode_stage_if.sv
// ----------------------------------------------------------------------------
// decode_stage_if
// Handshake bundle for the decode pipeline stage.
//   Input channel : in_valid/in_ready, in_instr, in_pc, in_tag
//   Output channel: out_valid/out_ready, out_instr, out_pc, out_tag, the
//                   decoded control bundle, out_system and out_illegal
// Modports:
//   master - upstream producer / downstream consumer side (drives in_* and
//            out_ready)
//   slave  - the decode stage itself
// ----------------------------------------------------------------------------
interface decode_stage_if #(
    parameter int PC_W  = 32,
    parameter int TAG_W = 4
);
    // input channel
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [PC_W-1:0]  in_pc;
    logic [TAG_W-1:0] in_tag;

    // output channel
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic [PC_W-1:0]  out_pc;
    logic [TAG_W-1:0] out_tag;
    logic             out_reg_write;
    logic [2:0]       out_imm_src;
    logic [1:0]       out_alu_src;
    logic             out_mem_write;
    logic [1:0]       out_result_src;
    logic             out_branch;
    logic             out_jump;
    logic             out_jump_src;
    logic             out_system;
    logic             out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, in_tag, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_tag,
               out_reg_write, out_imm_src, out_alu_src, out_mem_write,
               out_result_src, out_branch, out_jump, out_jump_src,
               out_system, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, in_tag, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_tag,
               out_reg_write, out_imm_src, out_alu_src, out_mem_write,
               out_result_src, out_branch, out_jump, out_jump_src,
               out_system, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// ----------------------------------------------------------------------------
// decode_stage
// Registered opcode-decode pipeline stage with a two-entry skid buffer.
// An instruction is decoded once when it is accepted; the resulting bundle
// is stored in OUT (drives the outputs) or SKID (overflow while OUT stalls).
// Ports:
//   clk           - rising-edge clock
//   rst_n         - asynchronous active-low reset
//   flush         - drops OUT, SKID and any input presented this cycle
//   ifc           - decode_stage_if.slave: input and output handshakes,
//                   passthrough fields and decoded control bundle
//   illegal_count - saturating count of accepted illegal instructions
// ----------------------------------------------------------------------------
module decode_stage #(
    parameter int PC_W      = 32,
    parameter int TAG_W     = 4,
    parameter int ILL_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    decode_stage_if.slave        ifc,
    output logic [ILL_CNT_W-1:0] illegal_count
);
    // opcode map
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALUR   = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // field encodings
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;
    localparam logic [1:0] ALU_REG = 2'd0;
    localparam logic [1:0] ALU_IMM = 2'd1;
    localparam logic [1:0] ALU_PC  = 2'd2;
    localparam logic [1:0] RES_ALU = 2'd0;
    localparam logic [1:0] RES_MEM = 2'd1;
    localparam logic [1:0] RES_PC4 = 2'd2;
    localparam logic       JMP_PC  = 1'b0;
    localparam logic       JMP_REG = 1'b1;

    typedef struct packed {
        logic             valid;
        logic [31:0]      instr;
        logic [PC_W-1:0]  pc;
        logic [TAG_W-1:0] tag;
        logic             reg_write;
        logic [2:0]       imm_src;
        logic [1:0]       alu_src;
        logic             mem_write;
        logic [1:0]       result_src;
        logic             branch;
        logic             jump;
        logic             jump_src;
        logic             system;
        logic             illegal;
    } entry_t;

    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    entry_t dec;
    logic [ILL_CNT_W-1:0] cnt_q, cnt_d;
    logic accept;
    logic out_fire;

    // ---------------- combinational decode of the incoming word ----------------
    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        dec.instr = ifc.in_instr;
        dec.pc    = ifc.in_pc;
        dec.tag   = ifc.in_tag;
        case (ifc.in_instr[6:0])
            OP_LOAD: begin
                dec.reg_write = 1'b1; dec.imm_src = IMM_I; dec.alu_src = ALU_IMM;
                dec.result_src = RES_MEM;
            end
            OP_ALUI: begin
                dec.reg_write = 1'b1; dec.imm_src = IMM_I; dec.alu_src = ALU_IMM;
                dec.result_src = RES_ALU;
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1; dec.imm_src = IMM_U; dec.alu_src = ALU_PC;
                dec.result_src = RES_ALU;
            end
            OP_STORE: begin
                dec.imm_src = IMM_S; dec.alu_src = ALU_IMM; dec.mem_write = 1'b1;
            end
            OP_ALUR: begin
                dec.reg_write = 1'b1; dec.imm_src = IMM_I; dec.alu_src = ALU_REG;
            end
            OP_LUI: begin
                dec.reg_write = 1'b1; dec.imm_src = IMM_U; dec.alu_src = ALU_IMM;
            end
            OP_BRANCH: begin
                dec.imm_src = IMM_B; dec.alu_src = ALU_REG; dec.branch = 1'b1;
            end
            OP_JALR: begin
                dec.reg_write = 1'b1; dec.imm_src = IMM_I; dec.alu_src = ALU_IMM;
                dec.result_src = RES_PC4; dec.jump = 1'b1; dec.jump_src = JMP_REG;
            end
            OP_JAL: begin
                dec.reg_write = 1'b1; dec.imm_src = IMM_J; dec.alu_src = ALU_REG;
                dec.result_src = RES_PC4; dec.jump = 1'b1; dec.jump_src = JMP_PC;
            end
            OP_SYSTEM: dec.system  = 1'b1;
            default:   dec.illegal = 1'b1;   // forwarded anyway so it can trap
        endcase
    end

    // ---------------- handshake and storage steering ----------------
    // in_ready depends only on SKID occupancy, so there is no combinational
    // path from out_ready back to in_ready.
    assign accept   = ifc.in_valid & ~skid_q.valid & ~flush;
    assign out_fire = out_q.valid & ifc.out_ready;

    always_comb begin
        out_d  = out_q;
        skid_d = skid_q;
        cnt_d  = cnt_q;
        if (flush) begin
            // flush beats accept, fire and skid move; data fields may stay stale
            out_d.valid  = 1'b0;
            skid_d.valid = 1'b0;
        end else begin
            if (out_fire) begin
                if (skid_q.valid) begin
                    out_d        = skid_q;
                    skid_d.valid = 1'b0;
                end else begin
                    out_d.valid = 1'b0;
                end
            end
            if (accept) begin
                // OUT takes the new word only if it is (or is becoming) free and
                // nothing older is waiting in SKID; otherwise SKID keeps order.
                if (!out_q.valid || (out_fire && !skid_q.valid)) begin
                    out_d = dec;
                end else begin
                    skid_d = dec;
                end
                if (dec.illegal && (cnt_q != '1)) begin
                    cnt_d = cnt_q + ILL_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            skid_q <= '0;
            cnt_q  <= '0;
        end else begin
            out_q  <= out_d;
            skid_q <= skid_d;
            cnt_q  <= cnt_d;
        end
    end

    // ---------------- outputs straight from OUT ----------------
    assign ifc.in_ready       = ~skid_q.valid;
    assign ifc.out_valid      = out_q.valid;
    assign ifc.out_instr      = out_q.instr;
    assign ifc.out_pc         = out_q.pc;
    assign ifc.out_tag        = out_q.tag;
    assign ifc.out_reg_write  = out_q.reg_write;
    assign ifc.out_imm_src    = out_q.imm_src;
    assign ifc.out_alu_src    = out_q.alu_src;
    assign ifc.out_mem_write  = out_q.mem_write;
    assign ifc.out_result_src = out_q.result_src;
    assign ifc.out_branch     = out_q.branch;
    assign ifc.out_jump       = out_q.jump;
    assign ifc.out_jump_src   = out_q.jump_src;
    assign ifc.out_system     = out_q.system;
    assign ifc.out_illegal    = out_q.illegal;
    assign illegal_count      = cnt_q;

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised opcode-decode pipeline stage for the processor control path. Accepts one 32-bit instruction per cycle with a PC and thread tag over a valid/ready handshake. Produces the full control bundle plus an illegal-instruction flag one cycle later. Adds a two-entry skid buffer, flush, AUIPC/SYSTEM decode and a saturating illegal-instruction counter on top of the combinational opcode table.

## Interface
- `PC_W`, 32, width of carried PC
- `TAG_W`, 4, width of carried thread/warp tag (≥1)
- `ILL_CNT_W`, 16, width of illegal-instruction counter (≥1)

- `clk` in 1 — rising-edge clock
- `rst_n` in 1 — reset, **asynchronous and active-low**
- `flush` in 1 — drop all held and incoming instructions
- `in_valid` in 1 / `in_ready` out 1 — input handshake
- `in_instr` in 32, `in_pc` in PC_W, `in_tag` in TAG_W — instruction word, PC, tag
- `out_valid` out 1 / `out_ready` in 1 — output handshake
- `out_instr` out 32, `out_pc` out PC_W, `out_tag` out TAG_W — passthrough
- `out_reg_write` out 1, `out_imm_src` out 3, `out_alu_src` out 2, `out_mem_write` out 1, `out_result_src` out 2, `out_branch` out 1, `out_jump` out 1, `out_jump_src` out 1 — control bundle
- `out_system` out 1 — SYSTEM-class instruction
- `out_illegal` out 1 — undecodable instruction
- `illegal_count` out ILL_CNT_W — saturating count of accepted illegal instructions

## Operation
- Encodings:
  - imm_src: I=0, S=1, B=2, U=3, J=4.
  - alu_src: REG=0, IMM=1, PC=2.
  - result_src: ALU=0, MEM=1, PC+4=2.
  - jump_src: PC=0, REG=1.
- Decode table, keyed on `instr[6:0]`; fields are {reg_write, imm_src, alu_src, mem_write, result_src, branch, jump, jump_src}:
  - 0000011 load {1,I,IMM,0,MEM,0,0,PC}
  - 0010011 ALU-I {1,I,IMM,0,ALU,0,0,PC}
  - 0010111 auipc {1,U,PC,0,ALU,0,0,PC}
  - 0100011 store {0,S,IMM,1,ALU,0,0,PC}
  - 0110011 ALU-R {1,I,REG,0,ALU,0,0,PC}
  - 0110111 lui {1,U,IMM,0,ALU,0,0,PC}
  - 1100011 branch {0,B,REG,0,ALU,1,0,PC}
  - 1100111 jalr {1,I,IMM,0,PC+4,0,1,REG}
  - 1101111 jal {1,J,REG,0,PC+4,0,1,PC}
  - 1110011 system: all fields 0, `out_system`=1
- Any other opcode is illegal: all control fields 0, `out_system`=0, `out_illegal`=1. The instruction is still forwarded downstream for trapping.
- Storage: output register (OUT) plus skid register (SKID), each holding {valid, instr, pc, tag, decoded bundle}.
- Decode is performed once, at acceptance; registered bundles never re-decode.
- Accept = `in_valid & in_ready & ~flush`.
- On accept:
  - if OUT is empty, or OUT fires this cycle (`out_valid & out_ready`) while SKID is empty, the decoded bundle loads OUT;
  - otherwise it loads SKID.
- OUT fires while SKID is valid: SKID moves to OUT and SKID clears. A simultaneous accept then loads SKID.
- `in_ready` = ~SKID.valid (registered state, no combinational path from `out_ready`).
- `out_valid` and all `out_*` fields come directly from OUT. While `out_valid`=1 and `out_ready`=0 they hold stable.
- Order is preserved; no instruction is duplicated or lost except by flush.
- `flush`:
  - next cycle, OUT.valid=0 and SKID.valid=0;
  - an input presented during the flush cycle is dropped (not accepted, not counted);
  - `illegal_count` is unaffected.
- `illegal_count` increments by 1 on each accept with the illegal flag set. It saturates at 2^ILL_CNT_W−1.

## Timing
- Reset (async assert, sync-to-clk release):
  - `out_valid`=0, `in_ready`=1, `illegal_count`=0;
  - all `out_*` data/control fields 0.
- Latency: accept at edge N → `out_valid`=1 after edge N (visible in cycle N+1).
- Throughput: 1 instr/cycle with `out_ready` held at 1.
- Backpressure:
  - with `out_ready`=0, two instructions are accepted, then `in_ready`=0 in the next cycle;
  - `in_ready` returns to 1 one cycle after the first output fire that drains SKID.
- Flush has priority over every simultaneous event (accept, fire, skid move).
- Reset asserted mid-operation clears all state immediately, independent of `clk`.

## Test plan
- **Single decode.** After reset, send `in_instr`=0x0000A083 (lw), pc=0x100, tag=3, with `out_ready`=1. Next cycle: `out_valid`=1, reg_write=1, imm_src=0, alu_src=1, result_src=1, mem_write=0, jump=0, pc=0x100, tag=3.
- **Full table.** Stream all 10 legal opcodes plus 0x7F back-to-back with `out_ready`=1. Each bundle must match the table. 0x7F gives `out_illegal`=1 with controls 0. One output per cycle; `illegal_count`=1.
- **Backpressure.** Hold `out_ready`=0 and offer A, B, C.
  - A and B are accepted; `in_ready`=0 from the third cycle; C is held.
  - Raise `out_ready`: outputs are A, B, C in order; `in_ready` returns 1 the cycle after A fires.
- **Flush.** With OUT and SKID full, assert `flush` for 1 cycle with `in_valid`=1.
  - Next cycle: `out_valid`=0, `in_ready`=1.
  - The flushed input never appears at the output.
- **Counter saturation.** With `ILL_CNT_W`=2, send 5 illegal instructions → `illegal_count` reads 1, 2, 3, 3, 3. A flush does not change it.
- **Async reset mid-stream.** Drop `rst_n` between clock edges with both entries full. `out_valid`=0, `in_ready`=1 and `illegal_count`=0 immediately, before the next edge.
